// File: rtl/accel_axis_pkg.sv
// ============================================================================
//  accel_axis_pkg
//  Shared lane/strobe helpers and state encoding for the accelerator AXIS
//  packer and unpacker.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package accel_axis_pkg;

   localparam int c_MAX_STRB_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PACK  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   function automatic int calc_lanes(input int data_w, input int pix_w);
      return data_w / pix_w;
   endfunction

   function automatic int calc_spl(input int pix_w);
      return pix_w / 8;
   endfunction

   // Low n_bits strobe bits set; callers slice to their own strobe width.
   function automatic logic [c_MAX_STRB_W-1:0] strb_from_count(input int n_bits);
      logic [c_MAX_STRB_W-1:0] m;
      for (int b = 0; b < c_MAX_STRB_W; b++) begin
         m[b] = (b < n_bits);
      end
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/axis_out_reg.sv
// ============================================================================
//  axis_out_reg
//  Single-entry AXI4-Stream output register with load/hold handshake.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module axis_out_reg #(
   parameter int DATA_W = 32,
   parameter int STRB_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load_valid,
   input  logic [DATA_W-1:0] i_load_data,
   input  logic [STRB_W-1:0] i_load_strb,
   input  logic              i_load_last,
   output logic              o_load_ready,
   output logic [DATA_W-1:0] o_tdata,
   output logic [STRB_W-1:0] o_tstrb,
   output logic              o_tlast,
   output logic              o_tvalid,
   input  logic              i_tready
);

   logic [DATA_W-1:0] r_tdata;
   logic [STRB_W-1:0] r_tstrb;
   logic              r_tlast;
   logic              r_tvalid;
   logic              w_load_ready;

   // Free when empty or the current beat is leaving this cycle.
   assign w_load_ready = !r_tvalid || i_tready;
   assign o_load_ready = w_load_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tdata  <= '0;
         r_tstrb  <= '0;
         r_tlast  <= 1'b0;
         r_tvalid <= 1'b0;
      end else if (i_load_valid && w_load_ready) begin
         r_tdata  <= i_load_data;
         r_tstrb  <= i_load_strb;
         r_tlast  <= i_load_last;
         r_tvalid <= 1'b1;
      end else if (i_tready) begin
         r_tvalid <= 1'b0;
      end
   end

   assign o_tdata  = r_tdata;
   assign o_tstrb  = r_tstrb;
   assign o_tlast  = r_tlast;
   assign o_tvalid = r_tvalid;

endmodule

`default_nettype wire

// File: rtl/output_axis_packer.sv
// ============================================================================
//  output_axis_packer
//  Packs core pixels little-endian into AXIS beats with tstrb/tlast per frame.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module output_axis_packer
   import accel_axis_pkg::*;
#(
   parameter int C_AXIS_TDATA_WIDTH = 32,
   parameter int PIXEL_WIDTH        = 8,
   parameter int FRAME_LEN_WIDTH    = 24
) (
   input  logic                            m00_axis_aclk,
   input  logic                            m00_axis_areset,
   input  logic                            start,
   input  logic [FRAME_LEN_WIDTH-1:0]      frame_len,
   input  logic [PIXEL_WIDTH-1:0]          pix_tdata,
   input  logic                            pix_valid,
   output logic                            pix_ready,
   output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
   output logic                            m00_axis_tvalid,
   input  logic                            m00_axis_tready,
   output logic                            m00_axis_tlast,
   output logic                            busy,
   output logic                            frame_done
);

   localparam int c_LANES  = calc_lanes(C_AXIS_TDATA_WIDTH, PIXEL_WIDTH);
   localparam int c_SPL    = calc_spl(PIXEL_WIDTH);
   localparam int c_STRB_W = C_AXIS_TDATA_WIDTH / 8;
   localparam int c_LANE_W = (c_LANES > 1) ? $clog2(c_LANES) : 1;
   localparam logic [c_LANE_W-1:0]        c_LAST_LANE = c_LANE_W'(c_LANES - 1);
   localparam logic [c_LANE_W-1:0]        c_LANE_ONE  = c_LANE_W'(1);
   localparam logic [FRAME_LEN_WIDTH-1:0] c_REM_ONE   = FRAME_LEN_WIDTH'(1);

   state_t                          r_state;
   state_t                          w_state_next;
   logic [FRAME_LEN_WIDTH-1:0]      r_remaining;
   logic [c_LANE_W-1:0]             r_lane;
   logic [C_AXIS_TDATA_WIDTH-1:0]   r_pack;
   logic [c_STRB_W-1:0]             r_pack_strb;
   logic                            r_pack_last;
   logic                            r_pending;
   logic                            r_frame_done;

   logic [C_AXIS_TDATA_WIDTH-1:0]   w_pack_next;
   logic [c_MAX_STRB_W-1:0]         w_strb_all;
   logic [c_STRB_W-1:0]             w_beat_strb;
   logic                            w_unused_strb_hi;
   logic                            w_start_ok;
   logic                            w_accept;
   logic                            w_pix_last;
   logic                            w_beat_done;
   logic                            w_tlast_hs;
   logic                            w_load_valid;
   logic                            w_load_ready;
   logic [C_AXIS_TDATA_WIDTH-1:0]   w_load_data;
   logic [c_STRB_W-1:0]             w_load_strb;
   logic                            w_load_last;

   assign pix_ready  = (r_state == ST_PACK) && !r_pending;
   assign busy       = (r_state != ST_IDLE);
   assign frame_done = r_frame_done;

   assign w_start_ok  = (r_state == ST_IDLE) && start && (frame_len != '0);
   assign w_accept    = pix_valid && pix_ready;
   assign w_pix_last  = (r_remaining == c_REM_ONE);
   assign w_beat_done = w_accept && ((r_lane == c_LAST_LANE) || w_pix_last);
   assign w_tlast_hs  = m00_axis_tvalid && m00_axis_tready && m00_axis_tlast;

   always_comb begin
      w_pack_next = r_pack;
      w_pack_next[r_lane*PIXEL_WIDTH +: PIXEL_WIDTH] = pix_tdata;
      w_strb_all  = strb_from_count((int'(r_lane) + 1) * c_SPL);
      w_beat_strb = w_strb_all[c_STRB_W-1:0];
   end

   assign w_unused_strb_hi = ^w_strb_all;

   // A pending beat has priority; no pixel can be accepted while it waits.
   assign w_load_valid = r_pending || w_beat_done;
   assign w_load_data  = r_pending ? r_pack      : w_pack_next;
   assign w_load_strb  = r_pending ? r_pack_strb : w_beat_strb;
   assign w_load_last  = r_pending ? r_pack_last : w_pix_last;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_start_ok)              w_state_next = ST_PACK;
         ST_PACK:  if (w_accept && w_pix_last) w_state_next = ST_DRAIN;
         ST_DRAIN: if (w_tlast_hs)             w_state_next = ST_IDLE;
         default:                               w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
      if (m00_axis_areset) r_state <= ST_IDLE;
      else                 r_state <= w_state_next;
   end

   always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
      if (m00_axis_areset) begin
         r_remaining  <= '0;
         r_lane       <= '0;
         r_pack       <= '0;
         r_pack_strb  <= '0;
         r_pack_last  <= 1'b0;
         r_pending    <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= (r_state == ST_DRAIN) && w_tlast_hs;

         if (w_start_ok) begin
            r_remaining <= frame_len;
            r_lane      <= '0;
         end else if (w_accept) begin
            r_remaining <= r_remaining - c_REM_ONE;
            r_lane      <= w_beat_done ? '0 : r_lane + c_LANE_ONE;
         end

         if (r_pending) begin
            if (w_load_ready) begin
               r_pending <= 1'b0;
               r_pack    <= '0;
            end
         end else if (w_beat_done) begin
            if (w_load_ready) begin
               r_pack <= '0;
            end else begin
               r_pack      <= w_pack_next;
               r_pack_strb <= w_beat_strb;
               r_pack_last <= w_pix_last;
               r_pending   <= 1'b1;
            end
         end else if (w_accept) begin
            r_pack <= w_pack_next;
         end
      end
   end

   axis_out_reg #(
      .DATA_W (C_AXIS_TDATA_WIDTH),
      .STRB_W (c_STRB_W)
   ) u_out_reg (
      .clk          (m00_axis_aclk),
      .rst          (m00_axis_areset),
      .i_load_valid (w_load_valid),
      .i_load_data  (w_load_data),
      .i_load_strb  (w_load_strb),
      .i_load_last  (w_load_last),
      .o_load_ready (w_load_ready),
      .o_tdata      (m00_axis_tdata),
      .o_tstrb      (m00_axis_tstrb),
      .o_tlast      (m00_axis_tlast),
      .o_tvalid     (m00_axis_tvalid),
      .i_tready     (m00_axis_tready)
   );

endmodule

`default_nettype wire
